// File: rtl/usb_pid_pkg.sv
// Shared PID encodings, host sequencer states and small decode helpers for the
// USB host transaction controller.
package usb_pid_pkg;

    localparam int MAX_PAYLOAD = 64;

    typedef enum logic [2:0] {
        TX_IDLE = 3'b000,
        TX_DATA = 3'b001,
        TX_OUT  = 3'b010,
        TX_IN   = 3'b011,
        TX_ACK  = 3'b100
    } tx_pid_t;

    typedef enum logic [2:0] {
        RX_IDLE = 3'b000,
        RX_DATA = 3'b001,
        RX_ACK  = 3'b100,
        RX_NAK  = 3'b101,
        RX_BAD  = 3'b110
    } rx_pid_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_OUT_TOKEN,
        S_TOKEN_WAIT,
        S_OUT_DATA,
        S_OUT_DATA_WAIT,
        S_OUT_RESP,
        S_IN_TOKEN,
        S_IN_TOKEN_WAIT,
        S_IN_RESP,
        S_IN_DATA,
        S_IN_ACK,
        S_IN_ACK_WAIT,
        S_RETRY,
        S_DONE,
        S_FAIL
`ifdef USB_HOST_BACKOFF_EN
        , S_BACKOFF
`endif
    } host_state_t;

    // Single-cycle token/data/handshake states map one-to-one onto a TX strobe.
    function automatic tx_pid_t tx_pid_for_state(input host_state_t s);
        case (s)
            S_OUT_TOKEN: return TX_OUT;
            S_OUT_DATA:  return TX_DATA;
            S_IN_TOKEN:  return TX_IN;
            S_IN_ACK:    return TX_ACK;
            default:     return TX_IDLE;
        endcase
    endfunction

    function automatic logic host_drives_bus(input host_state_t s);
        case (s)
            S_OUT_TOKEN, S_TOKEN_WAIT, S_OUT_DATA, S_OUT_DATA_WAIT,
            S_IN_TOKEN, S_IN_TOKEN_WAIT, S_IN_ACK, S_IN_ACK_WAIT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_timed_state(input host_state_t s);
        case (s)
            S_OUT_RESP, S_IN_RESP, S_IN_DATA: return 1'b1;
`ifdef USB_HOST_BACKOFF_EN
            S_BACKOFF: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/host_resp_timer.sv
// Saturating cycle counter with synchronous clear/enable and a terminal-count
// compare; shared by response timeout and retry backoff.
module host_resp_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] count,
    output logic             expired
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == terminal);

endmodule

// File: rtl/usb_host_transaction_ctrl.sv
// Host-side USB transaction sequencer: token, data/handshake and retry control.
// Optional retry backoff is enabled by defining USB_HOST_BACKOFF_EN.
module usb_host_transaction_ctrl
    import usb_pid_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRIES    = 3,
    parameter int BACKOFF_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic       cmd_dir,
    input  logic [6:0] cmd_size,
    output logic       cmd_ready,
    input  logic [2:0] rx_packet,
    input  logic       tx_done,
    input  logic [6:0] buffer_occupancy,
    output logic [2:0] tx_packet,
    output logic       d_mode,
    output logic       clear,
    output logic       xfer_done,
    output logic       xfer_error,
    output logic [1:0] retry_count
);

    // Timer must hold both the response timeout and the largest backoff delay.
    localparam int BACKOFF_MAX = BACKOFF_CYCLES << MAX_RETRIES;
    localparam int TERM_MAX    = (TIMEOUT_CYCLES > BACKOFF_MAX) ? TIMEOUT_CYCLES : BACKOFF_MAX;
    localparam int TW          = $clog2(TERM_MAX + 1);
    localparam logic [TW-1:0] TIMEOUT_TERM = TW'(TIMEOUT_CYCLES);
    localparam logic [1:0]    RETRY_LIMIT  = 2'(MAX_RETRIES);

    host_state_t    state;
    host_state_t    next_state;
    logic           dir_q;
    logic [6:0]     size_q;
    logic           tok_sent;
    logic           occ_match;
    logic           rx_nak_bad;
    logic           timed_out;
    logic           tmr_clear;
    logic           tmr_en;
    logic           tmr_expired;
    logic [TW-1:0]  tmr_count;
    logic [TW-1:0]  tmr_term;

    assign occ_match  = (buffer_occupancy == size_q);
    assign rx_nak_bad = (rx_packet == RX_NAK) || (rx_packet == RX_BAD);
    // A saturated counter is treated as expired even if the terminal was missed.
    assign timed_out  = tmr_expired || (tmr_count == '1);
    assign tmr_clear  = is_timed_state(next_state) && (next_state != state);
    assign tmr_en     = is_timed_state(state);

`ifdef USB_HOST_BACKOFF_EN
    always_comb begin
        tmr_term = TIMEOUT_TERM;
        if (state == S_BACKOFF) begin
            tmr_term = TW'((BACKOFF_CYCLES << (int'(retry_count) - 1)) - 1);
        end
    end
`else
    assign tmr_term = TIMEOUT_TERM;
`endif

    host_resp_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (tmr_clear),
        .enable   (tmr_en),
        .terminal (tmr_term),
        .count    (tmr_count),
        .expired  (tmr_expired)
    );

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:          if (cmd_valid && cmd_ready) next_state = cmd_dir ? S_IN_TOKEN : S_OUT_TOKEN;
            S_OUT_TOKEN:     next_state = S_TOKEN_WAIT;
            S_TOKEN_WAIT:    if ((tx_done || tok_sent) && occ_match) next_state = S_OUT_DATA;
            S_OUT_DATA:      next_state = S_OUT_DATA_WAIT;
            S_OUT_DATA_WAIT: if (tx_done) next_state = S_OUT_RESP;
            S_OUT_RESP: begin
                if (rx_packet == RX_ACK)      next_state = S_DONE;
                else if (rx_nak_bad)          next_state = S_RETRY;
                else if (timed_out)           next_state = S_RETRY;
            end
            S_IN_TOKEN:      next_state = S_IN_TOKEN_WAIT;
            S_IN_TOKEN_WAIT: if (tx_done) next_state = S_IN_RESP;
            S_IN_RESP: begin
                if (rx_packet == RX_DATA)     next_state = S_IN_DATA;
                else if (rx_nak_bad)          next_state = S_RETRY;
                else if (timed_out)           next_state = S_RETRY;
            end
            // Data phase ends when RX returns to IDLE; a short buffer is a bad packet.
            S_IN_DATA: begin
                if (rx_packet == RX_IDLE)     next_state = occ_match ? S_IN_ACK : S_RETRY;
                else if (rx_packet == RX_BAD) next_state = S_RETRY;
                else if (timed_out)           next_state = S_RETRY;
            end
            S_IN_ACK:        next_state = S_IN_ACK_WAIT;
            S_IN_ACK_WAIT:   if (tx_done) next_state = S_DONE;
            S_RETRY: begin
                if (retry_count == RETRY_LIMIT) begin
                    next_state = S_FAIL;
                end else begin
`ifdef USB_HOST_BACKOFF_EN
                    next_state = S_BACKOFF;
`else
                    next_state = dir_q ? S_IN_TOKEN : S_OUT_TOKEN;
`endif
                end
            end
`ifdef USB_HOST_BACKOFF_EN
            S_BACKOFF:       if (timed_out) next_state = dir_q ? S_IN_TOKEN : S_OUT_TOKEN;
`endif
            S_DONE:          next_state = S_IDLE;
            S_FAIL:          next_state = S_IDLE;
            default:         next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from next_state so they are valid on state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            dir_q       <= 1'b0;
            size_q      <= '0;
            tok_sent    <= 1'b0;
            cmd_ready   <= 1'b1;
            tx_packet   <= TX_IDLE;
            d_mode      <= 1'b0;
            clear       <= 1'b0;
            xfer_done   <= 1'b0;
            xfer_error  <= 1'b0;
            retry_count <= '0;
        end else begin
            state <= next_state;
            if (state == S_IDLE && cmd_valid && cmd_ready) begin
                dir_q       <= cmd_dir;
                size_q      <= cmd_size;
                retry_count <= '0;
            end else if (state == S_RETRY && next_state != S_FAIL) begin
                retry_count <= retry_count + 2'd1;
            end
            if (state == S_TOKEN_WAIT) begin
                tok_sent <= tok_sent | tx_done;
            end else begin
                tok_sent <= 1'b0;
            end
            cmd_ready  <= (next_state == S_IDLE);
            tx_packet  <= tx_pid_for_state(next_state);
            d_mode     <= host_drives_bus(next_state);
            // OUT data stays buffered across retries; IN data is flushed.
            clear      <= (next_state == S_FAIL) ||
                          (state == S_RETRY && next_state != S_FAIL && dir_q);
            xfer_done  <= (next_state == S_DONE);
            xfer_error <= (next_state == S_FAIL);
        end
    end

endmodule

// File: tb/tb_usb_host_transaction_ctrl.sv
// Self-checking bench for usb_host_transaction_ctrl: per-cycle vector table plus
// sequences for reset-in-flight, timeout/rx collision and retry exhaustion.
module tb_usb_host_transaction_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_dir;
    logic [6:0] cmd_size;
    logic       cmd_ready;
    logic [2:0] rx_packet;
    logic       tx_done;
    logic [6:0] buffer_occupancy;
    logic [2:0] tx_packet;
    logic       d_mode;
    logic       clear;
    logic       xfer_done;
    logic       xfer_error;
    logic [1:0] retry_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       cv;
        logic       dir;
        logic [6:0] size;
        logic [2:0] rx;
        logic       txd;
        logic [6:0] occ;
        logic [2:0] e_tx;
        logic       e_dm;
        logic       e_clr;
        logic       e_done;
        logic       e_err;
        logic       e_rdy;
        logic [1:0] e_rc;
    } vec_t;

    vec_t vecs[$];

    usb_host_transaction_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_dir          (cmd_dir),
        .cmd_size         (cmd_size),
        .cmd_ready        (cmd_ready),
        .rx_packet        (rx_packet),
        .tx_done          (tx_done),
        .buffer_occupancy (buffer_occupancy),
        .tx_packet        (tx_packet),
        .d_mode           (d_mode),
        .clear            (clear),
        .xfer_done        (xfer_done),
        .xfer_error       (xfer_error),
        .retry_count      (retry_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: got no finish, want finish before 1ms");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic cv, input logic dir, input int size,
                                input int rx, input logic txd, input int occ,
                                input int etx, input logic edm, input logic eclr,
                                input logic edone, input logic eerr, input logic erdy,
                                input int erc);
        vec_t v;
        v.cv = cv;  v.dir = dir;  v.size = 7'(size);  v.rx = 3'(rx);
        v.txd = txd;  v.occ = 7'(occ);  v.e_tx = 3'(etx);  v.e_dm = edm;
        v.e_clr = eclr;  v.e_done = edone;  v.e_err = eerr;  v.e_rdy = erdy;
        v.e_rc = 2'(erc);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        cmd_valid        = v.cv;
        cmd_dir          = v.dir;
        cmd_size         = v.size;
        rx_packet        = v.rx;
        tx_done          = v.txd;
        buffer_occupancy = v.occ;
        tick();
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        logic [9:0] got;
        logic [9:0] want;
        got  = {tx_packet, d_mode, clear, xfer_done, xfer_error, cmd_ready, retry_count};
        want = {v.e_tx, v.e_dm, v.e_clr, v.e_done, v.e_err, v.e_rdy, v.e_rc};
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL vec%0d: got tx=%0d dm=%0b clr=%0b done=%0b err=%0b rdy=%0b rc=%0d want tx=%0d dm=%0b clr=%0b done=%0b err=%0b rdy=%0b rc=%0d",
                     idx, tx_packet, d_mode, clear, xfer_done, xfer_error, cmd_ready, retry_count,
                     v.e_tx, v.e_dm, v.e_clr, v.e_done, v.e_err, v.e_rdy, v.e_rc);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        int gap;
        logic seen;

        cmd_valid = 0; cmd_dir = 0; cmd_size = 0; rx_packet = 0;
        tx_done = 0; buffer_occupancy = 0; rst = 1;

        // OUT size 8, ACK; a second command while busy must be ignored.
        vecs.push_back(mk(1,0,8,0,0,8, 2,1,0,0,0,0,0));
        vecs.push_back(mk(1,1,9,0,0,8, 0,1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,8, 1,1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,8, 0,1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,8, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,4,0,8, 0,0,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,8, 0,0,0,0,0,1,0));
        // IN size 4, DATA then IDLE with full buffer; tx_done in IN_TOKEN ignored.
        vecs.push_back(mk(1,1,4,0,0,0, 3,1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0, 0,1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,2, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,4, 4,1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,4, 0,1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,4, 0,0,0,1,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,1,0));
        // IN size 4: short buffer, then BAD, then good data.
        vecs.push_back(mk(1,1,4,0,0,0, 3,1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 0,1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,1,0,0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,3, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0, 3,1,1,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,0, 0,1,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,1,0, 0,0,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,6,0,0, 0,0,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,0, 3,1,1,0,0,0,2));
        vecs.push_back(mk(0,0,0,0,0,0, 0,1,0,0,0,0,2));
        vecs.push_back(mk(0,0,0,0,1,0, 0,0,0,0,0,0,2));
        vecs.push_back(mk(0,0,0,1,0,0, 0,0,0,0,0,0,2));
        vecs.push_back(mk(0,0,0,0,0,4, 4,1,0,0,0,0,2));
        vecs.push_back(mk(0,0,0,0,0,4, 0,1,0,0,0,0,2));
        vecs.push_back(mk(0,0,0,0,1,4, 0,0,0,1,0,0,2));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,1,2));
        // OUT size 4: data held until buffer fills, then NAK, NAK, ACK.
        vecs.push_back(mk(1,0,4,0,0,3, 2,1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,3, 0,1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,3, 0,1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,4, 1,1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,4, 0,1,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,1,4, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,5,0,4, 0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,4, 2,1,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,4, 0,1,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,1,4, 1,1,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,4, 0,1,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,1,4, 0,0,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,5,0,4, 0,0,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,4, 2,1,0,0,0,0,2));
        vecs.push_back(mk(0,0,0,0,0,4, 0,1,0,0,0,0,2));
        vecs.push_back(mk(0,0,0,0,1,4, 1,1,0,0,0,0,2));
        vecs.push_back(mk(0,0,0,0,0,4, 0,1,0,0,0,0,2));
        vecs.push_back(mk(0,0,0,0,1,4, 0,0,0,0,0,0,2));
        vecs.push_back(mk(0,0,0,4,0,4, 0,0,0,1,0,0,2));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,1,2));

        tick();
        tick();
        checkValue("rst_ready", cmd_ready, 1);
        checkValue("rst_outs", {tx_packet, d_mode, clear, xfer_done, xfer_error, retry_count}, 0);
        rst = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i]);
        end

        // Reset while waiting on OUT data after one retry.
        cmd_valid = 1; cmd_dir = 0; cmd_size = 2; buffer_occupancy = 2; rx_packet = 0;
        tick(); cmd_valid = 0;
        tick();
        tx_done = 1; tick(); tx_done = 0;
        tick();
        tx_done = 1; tick(); tx_done = 0;
        rx_packet = 5; tick(); rx_packet = 0;
        tick();
        checkValue("rm_rc1", retry_count, 1);
        tick();
        tx_done = 1; tick(); tx_done = 0;
        tick();
        checkValue("rm_dmode", d_mode, 1);
        rst = 1; tick(); rst = 0;
        checkValue("rm_idle_outs", {cmd_ready, tx_packet, d_mode, clear, xfer_done, xfer_error, retry_count}, 10'b1_000_0000_00);
        cmd_valid = 1; tick(); cmd_valid = 0;
        checkValue("rm_restart", {tx_packet, retry_count}, {3'b010, 2'b00});
        tick();
        tx_done = 1; tick(); tx_done = 0;
        tick();
        tx_done = 1; tick(); tx_done = 0;
        rx_packet = 4; tick(); rx_packet = 0;
        checkValue("rm_done", {xfer_done, retry_count}, {1'b1, 2'b00});
        tick();

        // DATA arriving in the very cycle the IN response timer expires wins.
        cmd_valid = 1; cmd_dir = 1; cmd_size = 4; buffer_occupancy = 0;
        tick(); cmd_valid = 0;
        tick();
        tx_done = 1; tick(); tx_done = 0;
        repeat (255) tick();
        rx_packet = 1; tick();
        rx_packet = 0; buffer_occupancy = 4; tick();
        checkValue("col_ack", tx_packet, 4);
        tick();
        tx_done = 1; tick(); tx_done = 0;
        checkValue("col_done", xfer_done, 1);
        tick();
        buffer_occupancy = 0;

        // IN with no response at all: four timed-out attempts, then failure.
        cmd_valid = 1; cmd_dir = 1; cmd_size = 4;
        tick(); cmd_valid = 0;
        checkValue("to_tok0", tx_packet, 3);
        for (int a = 0; a < 4; a++) begin
            tick();
            tx_done = 1; tick(); tx_done = 0;
            gap = 0;
            seen = 0;
            while (!seen && gap < 400) begin
                tick();
                gap++;
                if (tx_packet == 3'b011 || xfer_error) seen = 1;
            end
            checkValue($sformatf("to_gap%0d", a), gap, 257);
            if (a < 3) begin
                checkValue($sformatf("to_retok%0d", a), {tx_packet, clear, retry_count},
                           {3'b011, 1'b1, 2'(a + 1)});
            end else begin
                checkValue("to_fail", {xfer_error, clear, retry_count}, {1'b1, 1'b1, 2'd3});
            end
        end
        tick();
        checkValue("to_idle", {cmd_ready, xfer_error, clear}, 3'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
